// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the MIPS pipeline datapath and the hazard/flush sequencer.
// master: datapath side (drives hazard inputs); slave: the sequencer.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_regwrite;
  logic [4:0]  ex_wr_reg;
  logic        mem_regwrite;
  logic [4:0]  mem_wr_reg;
  logic        mem_branch_taken;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        stall_err;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_regwrite, ex_wr_reg, mem_regwrite, mem_wr_reg,
           mem_branch_taken,
    input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, stall_err, stall_count,
           flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_regwrite, ex_wr_reg, mem_regwrite, mem_wr_reg,
           mem_branch_taken,
    output pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, stall_err, stall_count,
           flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush sequencer for the 5-stage MIPS pipeline (no forwarding).
// Define PIPELINE_HAZARD_STATS_EN to build the stall/flush statistics counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned MAX_STALL   = 16
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [7:0] BootLast = 8'(BOOT_CYCLES - 1);
  localparam logic [7:0] StallMax = 8'(MAX_STALL);

  typedef enum logic [1:0] {StBoot, StRun, StStall, StFlush} state_e;

  state_e     state_q, state_d;
  logic [7:0] boot_cnt_q, boot_cnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       stall_err_q, stall_err_d;
  logic       ex_hit, mem_hit, hazard;
  logic       stall_evt, branch_evt;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush;

  // $0 is hardwired, so a write to it never conflicts.
  assign ex_hit  = hz.ex_regwrite && (hz.ex_wr_reg != 5'd0) &&
                   ((hz.ex_wr_reg == hz.id_rs) || (hz.id_uses_rt && hz.ex_wr_reg == hz.id_rt));
  assign mem_hit = hz.mem_regwrite && (hz.mem_wr_reg != 5'd0) &&
                   ((hz.mem_wr_reg == hz.id_rs) || (hz.id_uses_rt && hz.mem_wr_reg == hz.id_rt));
  assign hazard  = ex_hit || mem_hit;

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    stall_cnt_d = stall_cnt_q;
    stall_err_d = stall_err_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_evt   = 1'b0;
    branch_evt  = 1'b0;
    unique case (state_q)
      StBoot: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        stall_cnt_d = 8'd0;
        if (boot_cnt_q == BootLast) begin
          state_d    = StRun;
          boot_cnt_d = 8'd0;
        end else begin
          boot_cnt_d = boot_cnt_q + 8'd1;
        end
      end
      StRun, StStall, StFlush: begin
        // In FLUSH the MEM stage holds a bubble, so its branch flag is stale.
        if (hz.mem_branch_taken && (state_q != StFlush)) begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          branch_evt  = 1'b1;
          stall_cnt_d = 8'd0;
          state_d     = StFlush;
        end else if (hazard) begin
          idex_flush = 1'b1;
          stall_evt  = 1'b1;
          state_d    = StStall;
          if (stall_cnt_q != StallMax) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
          end
          if (stall_cnt_d == StallMax) begin
            stall_err_d = 1'b1;
          end
        end else begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          stall_cnt_d = 8'd0;
          state_d     = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      boot_cnt_q  <= 8'd0;
      stall_cnt_q <= 8'd0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.stall_err   = stall_err_q;

`ifdef PIPELINE_HAZARD_STATS_EN
  logic [31:0] stall_count_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      if (stall_evt)  stall_count_q <= stall_count_q + 32'd1;
      if (branch_evt) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;
`else
  logic unused_evt;
  assign unused_evt     = stall_evt ^ branch_evt;
  assign hz.stall_count = 32'd0;
  assign hz.flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned Boot = 4;
  localparam int unsigned MaxS = 3;
`ifdef PIPELINE_HAZARD_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .BOOT_CYCLES (Boot),
    .MAX_STALL   (MaxS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  // Reference model: cycles of boot left, one-cycle branch shadow, consecutive stall length.
  int          boot_left;
  bit          in_shadow;
  int          run_len;
  bit          m_err;
  logic [31:0] m_stalls;
  logic [31:0] m_flushes;

  task automatic model_reset();
    boot_left = Boot;
    in_shadow = 1'b0;
    run_len   = 0;
    m_err     = 1'b0;
    m_stalls  = 32'd0;
    m_flushes = 32'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit conflicts(input logic we, input logic [4:0] w);
    return we && (w != 5'd0) &&
           ((w == hz.id_rs) || (hz.id_uses_rt && (w == hz.id_rt)));
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic exr, input logic [4:0] exw,
                       input logic memr, input logic [4:0] memw, input logic br);
    hz.id_rs            = rs;
    hz.id_rt            = rt;
    hz.id_uses_rt       = urt;
    hz.ex_regwrite      = exr;
    hz.ex_wr_reg        = exw;
    hz.mem_regwrite     = memr;
    hz.mem_wr_reg       = memw;
    hz.mem_branch_taken = br;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Compare at negedge, advance model at posedge, change inputs 1 unit later.
  task automatic cycle();
    bit         haz, br;
    logic [4:0] ctl_exp;
    @(negedge clk);
    haz = conflicts(hz.ex_regwrite, hz.ex_wr_reg) || conflicts(hz.mem_regwrite, hz.mem_wr_reg);
    br  = hz.mem_branch_taken && !in_shadow;
    if (boot_left > 0)  ctl_exp = 5'b00111;
    else if (br)        ctl_exp = 5'b11111;
    else if (haz)       ctl_exp = 5'b00010;
    else                ctl_exp = 5'b11000;
    check("ctl{pc,ifid_en,ifid_fl,idex_fl,exmem_fl}",
          {27'd0, hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_flush, hz.exmem_flush},
          {27'd0, ctl_exp});
    check("stall_err", {31'd0, hz.stall_err}, {31'd0, m_err});
    check("stall_count", hz.stall_count, Stats ? m_stalls : 32'd0);
    check("flush_count", hz.flush_count, Stats ? m_flushes : 32'd0);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (boot_left > 0) begin
      boot_left--;
    end else if (br) begin
      in_shadow = 1'b1;
      run_len   = 0;
      m_flushes = m_flushes + 32'd1;
    end else if (haz) begin
      in_shadow = 1'b0;
      if (run_len < MaxS) run_len++;
      if (run_len == MaxS) m_err = 1'b1;
      m_stalls = m_stalls + 32'd1;
    end else begin
      in_shadow = 1'b0;
      run_len   = 0;
    end
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    repeat (6) cycle();

    // Load-use: producer in EX, then in MEM.
    drive(5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0); cycle();
    drive(5'd8, 5'd9, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0); cycle();
    idle(); cycle();

    // $0 never conflicts; rt only when used.
    drive(5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0); cycle();
    drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0); cycle();
    drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0); cycle();
    idle(); cycle();

    // Branch over a stall, repeated branch in the shadow cycle.
    drive(5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0); cycle();
    drive(5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1); cycle();
    drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1); cycle();
    idle(); cycle();

    // Watchdog: five-cycle hazard, then clear.
    drive(5'd4, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0); repeat (5) cycle();
    idle(); repeat (3) cycle();

    // Reset during a stall with counters nonzero.
    drive(5'd6, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0); repeat (2) cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; repeat (2) cycle();
    idle(); repeat (4) cycle();

    // Random traffic on a small register window to make conflicts frequent.
    for (int i = 0; i < 2000; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0));
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    idle(); repeat (8) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and flush sequencer for the 5-stage 32-bit MIPS pipeline. It is the only block allowed to drive the PC enable and the IF/ID, ID/EX and EX/MEM write/flush controls. The pipeline has no forwarding, so it stalls decode on any read-after-write against the EX or MEM stage. It flushes the three younger stages when a branch resolves taken in MEM, and holds the pipe idle for a fixed boot window after reset.

## Interface

Parameters:
- BOOT_CYCLES, 4: cycles after reset release with PC frozen and pipe flushed (1..255).
- MAX_STALL, 16: consecutive stall cycles that set `stall_err` (2..255).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  1 when the ID instruction reads rt (R-type, beq, sw).
- ex_regwrite  in  1  RegWrite of the instruction in EX.
- ex_wr_reg  in  5  destination register of EX (post RegDst mux).
- mem_regwrite  in  1  RegWrite of the instruction in MEM.
- mem_wr_reg  in  5  destination register of MEM.
- mem_branch_taken  in  1  Branch AND zero_flag in MEM (PCSrc).
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP (all-zero) instead of the fetched word.
- idex_flush  out  1  ID/EX control fields cleared (bubble).
- exmem_flush  out  1  EX/MEM control fields cleared.
- stall_err  out  1  sticky: a stall lasted MAX_STALL cycles.
- stall_count  out  32  stall cycles counted (statistics).
- flush_count  out  32  branch flushes counted (statistics).

## Operation

- States: BOOT, RUN, STALL, FLUSH.
- `hazard` is combinational and true when either of these holds:
  - ex_regwrite and ex_wr_reg≠0 and (ex_wr_reg==id_rs, or id_uses_rt and ex_wr_reg==id_rt).
  - The same test on the mem_* inputs.
- Register $0 never causes a hazard.
- WB-stage conflicts are not detected. The register file writes in the first half-cycle.
- BOOT:
  - Outputs: pc_en=0, ifid_en=0, all three flushes=1.
  - The boot counter runs 0..BOOT_CYCLES-1, then the FSM goes to RUN.
  - Inputs are ignored.
- RUN / STALL, evaluated in priority order:
  1. mem_branch_taken:
     - pc_en=1, ifid_en=1, ifid_flush=idex_flush=exmem_flush=1.
     - Next state is FLUSH. The stall counter clears. The branch overrides any hazard.
  2. hazard:
     - pc_en=0, ifid_en=0, idex_flush=1, others 0.
     - Next state is STALL. The consecutive-stall counter increments, saturating at MAX_STALL.
  3. Otherwise:
     - pc_en=1, ifid_en=1, flushes=0.
     - Next state is RUN. The stall counter clears.
- FLUSH:
  - Lasts exactly one cycle. mem_branch_taken is ignored because MEM holds a bubble.
  - The hazard test still applies, with the same outputs as RUN.
  - Next state is STALL on hazard, else RUN.
- stall_err:
  - Set on the edge where the consecutive-stall counter reaches MAX_STALL.
  - Cleared only by rst. It has no effect on control outputs.

## Timing

- Control outputs are Mealy: combinational from state plus current inputs, valid in the same cycle.
- State, counters and stall_err are registered.
- Reset values while rst=1 and on the cycle after release:
  - state=BOOT, pc_en=0, ifid_en=0, all flushes=1.
  - stall_err=0, stall_count=0, flush_count=0.
- The first pc_en=1 comes BOOT_CYCLES cycles after the first clock edge with rst=0.
- Load-use penalty without forwarding:
  - Up to 2 stall cycles when the producer is in EX.
  - 1 stall cycle when the producer is in MEM.
- Branch penalty: 3 instructions discarded, 1 cycle in FLUSH.
- rst asserted mid-STALL or mid-FLUSH returns to BOOT on the next edge. Counters and stall_err clear.

## Configuration

- Macro: `PIPELINE_HAZARD_STATS_EN`.
- Defined:
  - stall_count increments each cycle the hazard-stall outputs are driven.
  - flush_count increments each cycle mem_branch_taken is accepted.
  - Both are 32-bit, wrap at 2^32 and clear on rst.
- Undefined: both outputs tie to 32'd0 and the counter flops are not built.
- Control behaviour is identical either way.

## Test plan

- Boot window:
  - Stimulus: BOOT_CYCLES=4, rst high 2 cycles then low.
  - Required: pc_en=0 and ifid_flush=1 for exactly 4 cycles, then pc_en=1.
- Load-use:
  - Stimulus: ex_regwrite=1, ex_wr_reg=8, id_rs=8 for 1 cycle. Next cycle mem_regwrite=1, mem_wr_reg=8, ex_regwrite=0.
  - Required: 2 cycles of pc_en=0, ifid_en=0, idex_flush=1, then RUN. With the stats macro on, stall_count=2.
- $0 and rt gating:
  - Stimulus (1): ex_wr_reg=0 matching id_rs=0 with ex_regwrite=1. Required: no stall.
  - Stimulus (2): id_rt match with id_uses_rt=0. Required: no stall.
- Branch over stall:
  - Stimulus: in STALL, assert mem_branch_taken=1.
  - Required: all three flushes=1 and pc_en=1 that cycle; one FLUSH cycle follows; a repeated mem_branch_taken in FLUSH is ignored; flush_count=1.
- Stall watchdog:
  - Stimulus: MAX_STALL=3, hold the hazard 5 cycles.
  - Required: stall_err rises at the 3rd stall edge and stays 1 after the hazard clears, until rst.
- Reset mid-operation:
  - Stimulus: assert rst during STALL with counters nonzero.
  - Required: next cycle BOOT outputs, stall_err=0, stall_count=0, flush_count=0.
